// File: rtl/neuron_pkg.sv
// Shared constants for the neuron byte-stream loader: command opcodes,
// FSM state encoding and reset values of the neuron configuration.
package neuron_pkg;

  localparam logic [1:0] OP_LOAD_INPUTS  = 2'b00;
  localparam logic [1:0] OP_LOAD_WEIGHTS = 2'b01;
  localparam logic [1:0] OP_LOAD_PARAMS  = 2'b10;
  localparam logic [1:0] OP_STEP         = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'b00;
  localparam state_t ST_LOAD    = 2'b01;
  localparam state_t ST_STEP    = 2'b10;
  localparam state_t ST_CAPTURE = 2'b11;

  // bn_factor 4'b0100 is unity scale
  localparam logic [3:0] BN_FACTOR_RST = 4'b0100;
  localparam int         THRESHOLD_RST = 1;

endpackage

// File: rtl/neuron_stream_loader_deser.sv
// Byte deserializer: writes accepted bytes LS-first into a shadow register and
// presents the word with the current byte already merged, so the caller can
// commit atomically on the edge that accepts the last byte.
module byte_deserializer #(
  parameter int WIDTH = 32,
  parameter int NB    = WIDTH / 8,
  parameter int CW    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [7:0]       i_byte,
  input  logic [CW-1:0]    i_last_idx,
  output logic [WIDTH-1:0] o_word,
  output logic             o_last
);

  logic [WIDTH-1:0] r_shadow;
  logic [CW-1:0]    r_cnt;

  assign o_last = i_load && (r_cnt == i_last_idx);

  always_comb begin
    o_word = r_shadow;
    o_word[{r_cnt, 3'b000} +: 8] = i_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_shadow <= o_word;
      r_cnt    <= o_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/neuron_stream_loader.sv
// Byte-stream front end for neuron_lif: command decode, atomic config commit,
// step pulse and spike capture. Macro LOADER_AUTO_STEP_EN: a committed
// LOAD_INPUTS payload steps the neuron without a STEP byte.
//
// state      | meaning
// ST_IDLE    | waiting for a command byte
// ST_LOAD    | collecting payload bytes into the shadow register
// ST_STEP    | neuron_enable high for this single cycle
// ST_CAPTURE | spike_out updated, spike_valid high
import neuron_pkg::*;

module neuron_stream_loader #(
  parameter int SYNAPSES       = 32,
  parameter int THRESHOLD_BITS = $clog2(SYNAPSES) + 1,
  parameter int STEP_CNT_BITS  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [SYNAPSES-1:0]       neuron_inputs,
  output logic [SYNAPSES-1:0]       neuron_weights,
  output logic [2:0]                neuron_shift,
  output logic [3:0]                neuron_bn_factor,
  output logic [THRESHOLD_BITS-1:0] neuron_threshold,
  output logic                      neuron_enable,
  input  logic                      neuron_is_spike,
  output logic                      spike_out,
  output logic                      spike_valid,
  output logic [STEP_CNT_BITS-1:0]  step_count
);

  // params need 16 bits of shadow even for an 8-synapse neuron
  localparam int DW   = (SYNAPSES < 16) ? 16 : SYNAPSES;
  localparam int NB_D = DW / 8;
  localparam int CW   = (NB_D > 1) ? $clog2(NB_D) : 1;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [1:0]                r_op;
  logic [SYNAPSES-1:0]       r_inputs;
  logic [SYNAPSES-1:0]       r_weights;
  logic [2:0]                r_shift;
  logic [3:0]                r_bn;
  logic [THRESHOLD_BITS-1:0] r_thr;
  logic                      r_spike;
  logic [STEP_CNT_BITS-1:0]  r_step_cnt;

  logic          w_accept;
  logic          w_load_byte;
  logic [CW-1:0] w_last_idx;
  logic [DW-1:0] w_word;
  logic          w_last;

  assign in_ready    = rst_n && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign w_accept    = in_valid && in_ready;
  assign w_load_byte = w_accept && (r_state == ST_LOAD);
  assign w_last_idx  = (r_op == OP_LOAD_PARAMS) ? CW'(1) : CW'(NB_D - 1);

  byte_deserializer #(.WIDTH(DW)) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load_byte),
    .i_byte     (in_data),
    .i_last_idx (w_last_idx),
    .o_word     (w_word),
    .o_last     (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = (in_data[7:6] == OP_STEP) ? ST_STEP : ST_LOAD;
      end
      ST_LOAD: begin
        if (w_last) begin
`ifdef LOADER_AUTO_STEP_EN
          w_state_nxt = (r_op == OP_LOAD_INPUTS) ? ST_STEP : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      ST_STEP:    w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD_INPUTS;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && (r_state == ST_IDLE)) r_op <= in_data[7:6];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inputs  <= '0;
      r_weights <= '0;
      r_shift   <= '0;
      r_bn      <= BN_FACTOR_RST;
      r_thr     <= THRESHOLD_BITS'(THRESHOLD_RST);
    end else if (w_last) begin
      case (r_op)
        OP_LOAD_INPUTS:  r_inputs  <= w_word[SYNAPSES-1:0];
        OP_LOAD_WEIGHTS: r_weights <= w_word[SYNAPSES-1:0];
        OP_LOAD_PARAMS: begin
          r_shift <= w_word[7:5];
          r_bn    <= w_word[4:1];
          r_thr   <= w_word[8 +: THRESHOLD_BITS];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike    <= 1'b0;
      r_step_cnt <= '0;
    end else if (r_state == ST_STEP) begin
      r_spike    <= neuron_is_spike;
      r_step_cnt <= r_step_cnt + STEP_CNT_BITS'(1);
    end
  end

  assign neuron_inputs    = r_inputs;
  assign neuron_weights   = r_weights;
  assign neuron_shift     = r_shift;
  assign neuron_bn_factor = r_bn;
  assign neuron_threshold = r_thr;
  assign neuron_enable    = (r_state == ST_STEP);
  assign spike_valid      = (r_state == ST_CAPTURE);
  assign spike_out        = r_spike;
  assign step_count       = r_step_cnt;

endmodule

// File: tb/tb_neuron_stream_loader.sv
// Randomized self-checking bench for neuron_stream_loader against a
// transaction-level model of the command stream.
module tb_neuron_stream_loader;

  localparam int SYN = 32;
  localparam int TB  = 6;
  localparam int SCB = 10;
`ifdef LOADER_AUTO_STEP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     in_data = 8'h00;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [SYN-1:0] neuron_inputs, neuron_weights;
  logic [2:0]     neuron_shift;
  logic [3:0]     neuron_bn_factor;
  logic [TB-1:0]  neuron_threshold;
  logic           neuron_enable, neuron_is_spike, spike_out, spike_valid;
  logic [SCB-1:0] step_count;

  int n_total = 0;
  int n_bad   = 0;

  logic [SYN-1:0] m_in, m_w;
  logic [2:0]     m_shift;
  logic [3:0]     m_bn;
  int             m_thr;
  int             m_cnt;

  neuron_stream_loader #(.SYNAPSES(SYN), .THRESHOLD_BITS(TB), .STEP_CNT_BITS(SCB)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .neuron_inputs    (neuron_inputs),
    .neuron_weights   (neuron_weights),
    .neuron_shift     (neuron_shift),
    .neuron_bn_factor (neuron_bn_factor),
    .neuron_threshold (neuron_threshold),
    .neuron_enable    (neuron_enable),
    .neuron_is_spike  (neuron_is_spike),
    .spike_out        (spike_out),
    .spike_valid      (spike_valid),
    .step_count       (step_count)
  );

  always #5 clk = ~clk;

  // stand-in neuron: fires when matched synapse count reaches threshold
  assign neuron_is_spike = neuron_enable &&
                           ($countones(neuron_inputs & neuron_weights) >= int'(neuron_threshold));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_spike();
    return $countones(m_in & m_w) >= m_thr;
  endfunction

  task automatic model_reset();
    m_in = '0; m_w = '0; m_shift = 3'd0; m_bn = 4'b0100; m_thr = 1; m_cnt = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_in"},    neuron_inputs, m_in);
    chk({tag, "_w"},     neuron_weights, m_w);
    chk({tag, "_shift"}, neuron_shift, m_shift);
    chk({tag, "_bn"},    neuron_bn_factor, m_bn);
    chk({tag, "_thr"},   neuron_threshold, m_thr);
    chk({tag, "_cnt"},   step_count, m_cnt);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic watch_auto(input bit fire);
    int ne, nsv;
    logic sp;
    ne = 0; nsv = 0; sp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      ne += int'(neuron_enable);
      if (spike_valid) begin
        nsv++;
        sp = spike_out;
      end
    end
    chk("auto_en_pulses", ne, fire);
    chk("auto_sv_pulses", nsv, fire);
    if (fire) begin
      m_cnt = (m_cnt + 1) % (1 << SCB);
      chk("auto_spike", sp, model_spike());
      chk("auto_cnt", step_count, m_cnt);
    end
  endtask

  task automatic load_vec(input logic [1:0] op, input logic [SYN-1:0] v, input int gap);
    send_byte({op, 6'($urandom)}, gap);
    for (int i = 0; i < SYN / 8; i++) begin
      send_byte(v[i*8 +: 8], gap);
      if (i < SYN / 8 - 1) begin
        if (op == 2'b00) chk("in_held", neuron_inputs, m_in);
        else             chk("w_held", neuron_weights, m_w);
      end
    end
    if (op == 2'b00) m_in = v;
    else             m_w = v;
    chk("in_commit", neuron_inputs, m_in);
    chk("w_commit", neuron_weights, m_w);
    watch_auto(AUTO && (op == 2'b00));
  endtask

  task automatic load_params(input logic [7:0] b0, input logic [7:0] b1, input int gap);
    send_byte({2'b10, 6'($urandom)}, gap);
    send_byte(b0, gap);
    chk("thr_held", neuron_threshold, m_thr);
    chk("shift_held", neuron_shift, m_shift);
    send_byte(b1, gap);
    m_shift = b0[7:5];
    m_bn    = b0[4:1];
    m_thr   = int'(b1[TB-1:0]);
    chk("shift_commit", neuron_shift, m_shift);
    chk("bn_commit", neuron_bn_factor, m_bn);
    chk("thr_commit", neuron_threshold, m_thr);
  endtask

  task automatic do_step(input int gap);
    bit exp_sp;
    exp_sp = model_spike();
    send_byte({2'b11, 6'($urandom)}, gap);
    chk("step_en", neuron_enable, 1);
    chk("step_rdy", in_ready, 0);
    chk("step_sv", spike_valid, 0);
    @(posedge clk);
    #1;
    m_cnt = (m_cnt + 1) % (1 << SCB);
    chk("cap_en", neuron_enable, 0);
    chk("cap_sv", spike_valid, 1);
    chk("cap_spike", spike_out, exp_sp);
    chk("cap_cnt", step_count, m_cnt);
    chk("cap_rdy", in_ready, 0);
    @(posedge clk);
    #1;
    chk("post_sv", spike_valid, 0);
    chk("post_rdy", in_ready, 1);
    chk("post_spike_hold", spike_out, exp_sp);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_en", neuron_enable, 0);
    chk("rst_sv", spike_valid, 0);
    chk("rst_spike", spike_out, 0);
    chk_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);

    load_vec(2'b00, 32'hCAFE_F00D, 0);
    load_vec(2'b00, 32'h1234_5678, 3);
    chk("known_inputs", neuron_inputs, 32'h1234_5678);
    load_params(8'b011_0100_0, 8'h05, 0);
    chk("known_shift", neuron_shift, 3'd3);
    chk("known_thr", neuron_threshold, 6'd5);

    for (int t = 0; t < 40; t++) begin
      int sel, g;
      sel = $urandom_range(0, 3);
      g   = $urandom_range(0, 2);
      case (sel)
        0:       load_vec(2'b00, $urandom, g);
        1:       load_vec(2'b01, $urandom, g);
        2:       load_params(8'($urandom_range(0, 255)), 8'($urandom_range(0, 12)), g);
        default: do_step(g);
      endcase
      chk_outputs("rand");
    end

    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", in_ready, 0);
    chk("midrst_en", neuron_enable, 0);
    chk("midrst_sv", spike_valid, 0);
    chk("midrst_spike", spike_out, 0);
    chk_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_params(8'b010_0110_0, 8'h07, 0);
    chk_outputs("after_rst");

    load_vec(2'b00, 32'hFFFF_FFFF, 0);
    load_vec(2'b01, 32'hFFFF_FFFF, 1);
    load_params(8'b000_0100_0, 8'h05, 0);
    do_step(0);
    chk("first_step_cnt", step_count, 1);
    chk("first_step_spike", spike_out, 1);

    while (m_cnt != (1 << SCB) - 1) do_step(0);
    chk("pre_wrap_cnt", step_count, (1 << SCB) - 1);
    do_step(0);
    chk("wrap_cnt", step_count, 0);

    load_vec(2'b00, 32'h0F0F_0F0F, 0);
    load_vec(2'b01, 32'h00FF_00FF, 0);
    chk_outputs("final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
